// File: rtl/intr_ctrl_pkg.sv
// Shared types and default constants for the interrupt controller.
// Holds the arbitration FSM state encoding and the default vector layout.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h00FF;
  localparam int unsigned DEF_VECTOR_STRIDE = 4;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
// Returns a valid flag and the 4-bit index of the winner.
module prio_enc #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  // NOTE: every output of an always_comb block gets a default first, so no path can infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downward so the last hit, i.e. the lowest index, is the one kept.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches source events, arbitrates by fixed priority
// and runs a request/service handshake with the control unit.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned         NUM_SRC       = 8,
  parameter int unsigned         ADDR_W        = 16,
  parameter logic [ADDR_W-1:0]   VECTOR_BASE   = ADDR_W'(DEF_VECTOR_BASE),
  parameter int unsigned         VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  parameter logic [NUM_SRC-1:0]  EDGE_MASK     = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               gie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [ADDR_W-1:0]  irq_vector,
  output logic [3:0]         active_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] irq_hist_q, irq_hist_d;
  logic [3:0]         active_id_q, active_id_d;

  logic [NUM_SRC-1:0] set_evt;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] active_oh;
  logic               arb_valid;
  logic [3:0]         arb_idx;

  // Masking only gates arbitration; pending bits latch regardless.
  prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req   (pending_q & mask_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    set_evt     = (EDGE_MASK & irq_in & ~irq_hist_q) | (~EDGE_MASK & irq_in);
    active_oh   = NUM_SRC'(1) << active_id_q;
    state_d     = state_q;
    active_id_d = active_id_q;
    clr         = '0;
    mask_d      = mask_we ? mask_wdata : mask_q;
    irq_hist_d  = irq_in;

    case (state_q)
      ST_IDLE: begin
        if (gie && arb_valid) begin
          state_d     = ST_REQ;
          active_id_d = arb_idx;
        end
      end
      ST_REQ: begin
        // An accepted request beats a same-cycle abort condition.
        if (irq_ack) begin
          state_d = ST_SERVICE;
          clr     = active_oh;
        end else if (!gie || ((mask_q & active_oh) == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new event in the clearing cycle wins over the clear.
    pending_d = (pending_q & ~clr) | set_evt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_hist_q  <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_hist_q  <= irq_hist_d;
      active_id_q <= active_id_d;
    end
  end

  assign irq_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign active_id  = active_id_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign irq_vector = VECTOR_BASE + ADDR_W'(active_id_q) * ADDR_W'(VECTOR_STRIDE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a vector table for the main flow plus
// hand-written sequences for masking, gie drop, coincident set/clear, reset and level mode.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst, gie, mask_we, irq_ack, irq_done;
  logic [7:0]  irq_in, mask_wdata;
  logic        irq_req, in_service;
  logic [15:0] irq_vector;
  logic [3:0]  active_id;
  logic [7:0]  pending, mask;

  logic        l_rst, l_gie, l_we, l_ack, l_done;
  logic [7:0]  l_irq, l_wd;
  logic        l_req, l_svc;
  logic [15:0] l_vec;
  logic [3:0]  l_aid;
  logic [7:0]  l_pend, l_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  intr_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .gie        (gie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .active_id  (active_id),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  intr_ctrl #(.EDGE_MASK(8'h00)) u_lvl (
    .clk        (clk),
    .rst        (l_rst),
    .irq_in     (l_irq),
    .gie        (l_gie),
    .mask_we    (l_we),
    .mask_wdata (l_wd),
    .irq_ack    (l_ack),
    .irq_done   (l_done),
    .irq_req    (l_req),
    .irq_vector (l_vec),
    .active_id  (l_aid),
    .in_service (l_svc),
    .pending    (l_pend),
    .mask       (l_mask)
  );

  typedef struct {
    logic        rst;
    logic        gie;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  irq;
    logic        ack;
    logic        done;
    logic        e_req;
    logic [15:0] e_vec;
    logic [3:0]  e_aid;
    logic        e_svc;
    logic [7:0]  e_pend;
    logic [7:0]  e_mask;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic g, input logic we, input logic [7:0] wd,
                      input logic [7:0] irq, input logic ack, input logic done);
    rst = r; gie = g; mask_we = we; mask_wdata = wd; irq_in = irq; irq_ack = ack; irq_done = done;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [15:0] vec,
                            input logic [3:0] aid, input logic svc, input logic [7:0] pend,
                            input logic [7:0] msk);
    check({tag, " irq_req"},    32'(irq_req),    32'(req));
    check({tag, " irq_vector"}, 32'(irq_vector), 32'(vec));
    check({tag, " active_id"},  32'(active_id),  32'(aid));
    check({tag, " in_service"}, 32'(in_service), 32'(svc));
    check({tag, " pending"},    32'(pending),    32'(pend));
    check({tag, " mask"},       32'(mask),       32'(msk));
  endtask

  task automatic expect_lvl(input string tag, input logic req, input logic [3:0] aid,
                            input logic svc, input logic [7:0] pend);
    check({tag, " irq_req"},    32'(l_req),  32'(req));
    check({tag, " active_id"},  32'(l_aid),  32'(aid));
    check({tag, " in_service"}, 32'(l_svc),  32'(svc));
    check({tag, " pending"},    32'(l_pend), 32'(pend));
  endtask

  initial begin
    rst = 1'b1; gie = 1'b0; mask_we = 1'b0; mask_wdata = '0; irq_in = '0;
    irq_ack = 1'b0; irq_done = 1'b0;
    l_rst = 1'b1; l_gie = 1'b0; l_we = 1'b0; l_wd = '0; l_irq = '0; l_ack = 1'b0; l_done = 1'b0;

    //          rst  gie  we   wd     irq    ack  done | req  vec       aid   svc  pend   mask
    tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,16'h00FF,4'd0,1'b0,8'h00,8'h00};
    tbl[1]  = '{1'b0,1'b1,1'b1,8'hFF,8'h00,1'b0,1'b0, 1'b0,16'h00FF,4'd0,1'b0,8'h00,8'hFF};
    tbl[2]  = '{1'b0,1'b1,1'b0,8'h00,8'h08,1'b0,1'b0, 1'b0,16'h00FF,4'd0,1'b0,8'h08,8'hFF};
    tbl[3]  = '{1'b0,1'b1,1'b0,8'h00,8'h08,1'b0,1'b0, 1'b1,16'h010B,4'd3,1'b0,8'h08,8'hFF};
    tbl[4]  = '{1'b0,1'b1,1'b0,8'h00,8'h08,1'b0,1'b0, 1'b1,16'h010B,4'd3,1'b0,8'h08,8'hFF};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'h00,8'h08,1'b1,1'b0, 1'b0,16'h010B,4'd3,1'b1,8'h00,8'hFF};
    tbl[6]  = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,16'h010B,4'd3,1'b1,8'h00,8'hFF};
    tbl[7]  = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b1, 1'b0,16'h010B,4'd3,1'b0,8'h00,8'hFF};
    tbl[8]  = '{1'b0,1'b1,1'b0,8'h00,8'h24,1'b0,1'b0, 1'b0,16'h010B,4'd3,1'b0,8'h24,8'hFF};
    tbl[9]  = '{1'b0,1'b1,1'b0,8'h00,8'h24,1'b0,1'b0, 1'b1,16'h0107,4'd2,1'b0,8'h24,8'hFF};
    tbl[10] = '{1'b0,1'b1,1'b0,8'h00,8'h24,1'b1,1'b0, 1'b0,16'h0107,4'd2,1'b1,8'h20,8'hFF};
    tbl[11] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,16'h0107,4'd2,1'b1,8'h20,8'hFF};
    tbl[12] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b1, 1'b0,16'h0107,4'd2,1'b0,8'h20,8'hFF};
    tbl[13] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b1,16'h0113,4'd5,1'b0,8'h20,8'hFF};
    tbl[14] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,1'b0, 1'b0,16'h0113,4'd5,1'b1,8'h00,8'hFF};
    tbl[15] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b0,1'b1, 1'b0,16'h0113,4'd5,1'b0,8'h00,8'hFF};
    tbl[16] = '{1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,1'b1, 1'b0,16'h0113,4'd5,1'b0,8'h00,8'hFF};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].gie, tbl[i].we, tbl[i].wd, tbl[i].irq, tbl[i].ack, tbl[i].done);
      expect_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_vec, tbl[i].e_aid,
                 tbl[i].e_svc, tbl[i].e_pend, tbl[i].e_mask);
    end

    // Masking: pending latches while masked, request follows two cycles after the mask write.
    step(1, 0, 0, 8'h00, 8'h00, 0, 0); expect_out("msk rst",    0, 16'h00FF, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h00, 8'h02, 0, 0); expect_out("msk pulse",  0, 16'h00FF, 0, 0, 8'h02, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("msk hold1",  0, 16'h00FF, 0, 0, 8'h02, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("msk hold2",  0, 16'h00FF, 0, 0, 8'h02, 8'h00);
    step(0, 1, 1, 8'h02, 8'h00, 0, 0); expect_out("msk write",  0, 16'h00FF, 0, 0, 8'h02, 8'h02);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("msk req",    1, 16'h0103, 1, 0, 8'h02, 8'h02);
    // Masking the latched source during REQ aborts back to IDLE with pending kept.
    step(0, 1, 1, 8'h00, 8'h00, 0, 0); expect_out("msk unmask", 1, 16'h0103, 1, 0, 8'h02, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("msk abort",  0, 16'h0103, 1, 0, 8'h02, 8'h00);

    // gie drop while requesting source 0.
    step(1, 0, 0, 8'h00, 8'h00, 0, 0); expect_out("gie rst",    0, 16'h00FF, 0, 0, 8'h00, 8'h00);
    step(0, 1, 1, 8'hFF, 8'h00, 0, 0); expect_out("gie mask",   0, 16'h00FF, 0, 0, 8'h00, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h01, 0, 0); expect_out("gie pend",   0, 16'h00FF, 0, 0, 8'h01, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h01, 0, 0); expect_out("gie req",    1, 16'h00FF, 0, 0, 8'h01, 8'hFF);
    step(0, 0, 0, 8'h00, 8'h01, 0, 0); expect_out("gie drop",   0, 16'h00FF, 0, 0, 8'h01, 8'hFF);
    step(0, 0, 0, 8'h00, 8'h00, 1, 0); expect_out("gie low",    0, 16'h00FF, 0, 0, 8'h01, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("gie rise",   1, 16'h00FF, 0, 0, 8'h01, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h00, 1, 0); expect_out("gie ack",    0, 16'h00FF, 0, 1, 8'h00, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h00, 0, 1); expect_out("gie done",   0, 16'h00FF, 0, 0, 8'h00, 8'hFF);

    // Coincident set and clear on source 4.
    step(0, 1, 0, 8'h00, 8'h10, 0, 0); expect_out("coin pend",  0, 16'h00FF, 0, 0, 8'h10, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("coin req",   1, 16'h010F, 4, 0, 8'h10, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h10, 1, 0); expect_out("coin ack",   0, 16'h010F, 4, 1, 8'h10, 8'hFF);
    step(0, 1, 0, 8'h00, 8'h10, 0, 0); expect_out("coin svc",   0, 16'h010F, 4, 1, 8'h10, 8'hFF);

    // Reset mid-service, then a stray irq_done.
    step(1, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("rst svc",    0, 16'h00FF, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 0, 1); expect_out("rst done",   0, 16'h00FF, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 0, 0); expect_out("rst quiet",  0, 16'h00FF, 0, 0, 8'h00, 8'h00);

    // Level mode: a source held high re-pends through ack and re-requests after done.
    l_rst = 1'b0; l_gie = 1'b1; l_we = 1'b1; l_wd = 8'hFF; tick();
    check("lvl mask", 32'(l_mask), 32'h0000_00FF);
    l_we = 1'b0; l_irq = 8'h01; tick();  expect_lvl("lvl set",  0, 0, 0, 8'h01);
    tick();                              expect_lvl("lvl req",  1, 0, 0, 8'h01);
    check("lvl vec", 32'(l_vec), 32'h0000_00FF);
    l_ack = 1'b1; tick();                expect_lvl("lvl ack",  0, 0, 1, 8'h01);
    l_ack = 1'b0; l_irq = 8'h00; tick(); expect_lvl("lvl svc",  0, 0, 1, 8'h01);
    l_done = 1'b1; tick();               expect_lvl("lvl done", 0, 0, 0, 8'h01);
    l_done = 1'b0; tick();               expect_lvl("lvl rereq", 1, 0, 0, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL take parameters NUM_SRC (default 8, legal 1..16, interrupt source count) and ADDR_W (default 16, vector width).
REQ-002 The block SHALL take parameters VECTOR_BASE (default 16'h00FF, vector of source 0), VECTOR_STRIDE (default 4, address gap between vectors) and EDGE_MASK (default all ones; bit i=1 edge-triggered, 0 level-triggered).
REQ-003 The block SHALL have these ports:
  clk  in  1  single clock; all state changes on rising edge.
  rst  in  1  synchronous active-high reset.
  irq_in  in  NUM_SRC  raw source lines, synchronous to clk.
  gie  in  1  global interrupt enable from the status register.
  mask_we  in  1  mask write strobe.
  mask_wdata  in  NUM_SRC  new mask value; 1 = enabled.
  irq_ack  in  1  one-cycle pulse from control: request accepted.
  irq_done  in  1  one-cycle pulse from control: return-from-interrupt executed.
  irq_req  out  1  registered request to control.
  irq_vector  out  ADDR_W  jump target for the granted source.
  active_id  out  4  granted or in-service source index.
  in_service  out  1  handler running.
  pending  out  NUM_SRC  latched pending bits.
  mask  out  NUM_SRC  current mask register.

Function
REQ-004 In edge mode, pending[i] SHALL set on the cycle after irq_in[i] goes 0->1, using a registered copy of irq_in. In level mode it SHALL set on the cycle after irq_in[i] is sampled high.
REQ-005 Pending bits SHALL be set regardless of mask and gie. Masking SHALL only gate arbitration.
REQ-006 Arbitration SHALL be fixed priority over pending & mask: lowest index wins.
REQ-007 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-008 IDLE->REQ SHALL occur when gie=1 and (pending & mask) is nonzero. On that transition the winner index SHALL be latched into active_id.
REQ-009 irq_req SHALL be 1 exactly while the FSM is in REQ. A source edge in cycle n SHALL therefore give irq_req=1 at cycle n+2.
REQ-010 irq_vector SHALL equal VECTOR_BASE + active_id*VECTOR_STRIDE, truncated to ADDR_W, and SHALL be stable while irq_req=1.
REQ-011 In REQ, irq_ack SHALL clear pending[active_id] and move the FSM to SERVICE. in_service SHALL be 1 from the next cycle.
REQ-012 In REQ, if gie falls or the latched source becomes masked before irq_ack, the FSM SHALL return to IDLE with pending retained.
REQ-013 There SHALL be no preemption: a higher-priority arrival during REQ or SERVICE SHALL stay pending.
REQ-014 irq_done in SERVICE SHALL return the FSM to IDLE. irq_ack and irq_done outside their states SHALL be ignored.
REQ-015 If a new event on a source coincides with the irq_ack that clears it, the set SHALL win and pending SHALL stay 1.
REQ-016 A level source still high after ack SHALL re-pend on the next cycle.
REQ-017 mask_we SHALL update mask on the next edge and SHALL NOT alter pending.

Reset
REQ-018 rst SHALL force FSM=IDLE, pending=0, mask=0, the irq_in history register=0, active_id=0, irq_req=0 and in_service=0.
REQ-019 rst in any state, including REQ and SERVICE, SHALL abandon the transaction with no further output activity. Reset SHALL take priority over every other input.

Structure
REQ-020 A shared package SHALL hold the FSM state enum and the default VECTOR_BASE and VECTOR_STRIDE constants.
REQ-021 The fixed-priority encoder SHALL be a sub-module prio_enc, parameterised by NUM_SRC, returning a valid bit and an index.

Verification
REQ-022 Edge latency: defaults, gie=1, mask=8'hFF, irq_in[3] rises at cycle 10 -> pending[3]=1 at 11, irq_req=1 at 12, irq_vector=16'h010B, active_id=3.
REQ-023 Priority: irq_in[5] and irq_in[2] rise together -> grant 2, vector 16'h0107. Then ack, then done -> source 5 granted next with vector 16'h0113.
REQ-024 Masking: mask=8'h00, irq_in[1] pulses -> pending[1]=1 and irq_req stays 0. Write mask=8'h02 -> irq_req=1 two cycles later.
REQ-025 gie drop: in REQ for source 0, gie falls before ack -> IDLE, pending[0]=1. gie rises -> irq_req=1 again.
REQ-026 Coincident set and clear: edge on source 4 in the same cycle as ack for source 4 -> pending[4]=1 after the ack.
REQ-027 Reset mid-service: rst asserted in SERVICE -> next cycle all outputs 0. A subsequent irq_done is ignored.
